// File: rtl/xor2_wdff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor2_wdff_pkg
//  Description : Shared definitions for the registered-XOR2 response checker:
//                run-state encoding, the "no error seen" index marker and the
//                default parameter values shared with the cell's bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor2_wdff_pkg;

    // Default run configuration.
    localparam int C_DEF_NUM_CHECKS = 64;
    localparam int C_DEF_WARMUP     = 1;
    localparam int C_DEF_CNT_W      = 8;
    localparam int C_DEF_IDX_W      = 16;

    // First-error index value meaning "no mismatch seen" (default index width).
    localparam logic [C_DEF_IDX_W-1:0] IDX_NONE = '1;

    // Checker run state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : xor2_wdff_pkg
`default_nettype wire

// File: rtl/xor2_wdff_ref.sv
`default_nettype none
// ============================================================================
//  Module      : xor2_wdff_ref
//  Description : Golden copy of the registered XOR2 cell's output register.
//                EXP_Q <= IN_A ^ IN_B on every enabled rising edge, holds
//                otherwise. Usable standalone as a reference model.
//  Ports       : CLK   - clock, rising edge
//                RESET - asynchronous, active-high; clears EXP_Q
//                CE    - clock enable (same net as the cell's CE)
//                IN_A  - operand A
//                IN_B  - operand B
//                EXP_Q - expected registered output
//  Revision    : 1.0 - initial release
// ============================================================================
module xor2_wdff_ref (
    input  logic CLK,
    input  logic RESET,
    input  logic CE,
    input  logic IN_A,
    input  logic IN_B,
    output logic EXP_Q
);

    logic r_exp_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_exp_q <= 1'b0;
        end else if (CE) begin
            r_exp_q <= IN_A ^ IN_B;
        end
    end

    assign EXP_Q = r_exp_q;

endmodule : xor2_wdff_ref
`default_nettype wire

// File: rtl/xor2_wdff_checker.sv
`default_nettype none
// ============================================================================
//  Module      : xor2_wdff_checker
//  Description : On-chip response monitor for the registered XOR2 cell. Keeps
//                a reference copy of the cell's output register and compares
//                it with the cell output every cycle of a checking run.
//  Ports       : CLK           - clock, rising edge
//                RESET         - asynchronous, active-high; clears all state
//                CE            - clock enable shared with the cell
//                START         - one-cycle pulse that begins a run
//                IN_A, IN_B    - cell operands (same nets as the cell)
//                DUT_O         - registered output of the cell under check
//                BUSY          - high during warm-up and checking
//                DONE          - high after a run until next START/RESET
//                PASS          - valid with DONE; 1 when no mismatch counted
//                ERR_PULSE     - registered one-cycle strobe per mismatch
//                ERR_CNT       - saturating mismatch count of current run
//                FIRST_ERR_IDX - check index of first mismatch, all-ones if none
//  Revision    : 1.0 - initial release
// ============================================================================
module xor2_wdff_checker
    import xor2_wdff_pkg::*;
#(
    parameter int NUM_CHECKS = C_DEF_NUM_CHECKS,
    parameter int WARMUP     = C_DEF_WARMUP,
    parameter int CNT_W      = C_DEF_CNT_W,
    parameter int IDX_W      = C_DEF_IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             START,
    input  logic             IN_A,
    input  logic             IN_B,
    input  logic             DUT_O,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             ERR_PULSE,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [IDX_W-1:0] FIRST_ERR_IDX
);

    localparam logic [IDX_W-1:0] c_IDX_NONE  = '1;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [3:0]       c_WARM_LAST = (WARMUP > 0) ? 4'(WARMUP - 1) : 4'd0;
    localparam state_t           c_RUN_STATE = (WARMUP > 0) ? ST_WARM : ST_CHECK;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start_ok;
    logic             w_exp_q;
    logic             w_neq;
    logic [3:0]       r_warm_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_first_err_idx;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_err_pulse;

    // Reference register runs in every state so it tracks the cell from reset.
    xor2_wdff_ref u_ref (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .IN_A  (IN_A),
        .IN_B  (IN_B),
        .EXP_Q (w_exp_q)
    );

    // Cell output and reference are both registered on the same edge, so they
    // are compared directly in the same cycle. In simulation an X on DUT_O is
    // counted as a mismatch.
`ifdef SYNTHESIS
    assign w_neq = (DUT_O != w_exp_q);
`else
    assign w_neq = (DUT_O !== w_exp_q);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; START is only honoured when not busy.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = c_RUN_STATE;
                end
            end
            ST_WARM: begin
                if (r_warm_cnt == c_WARM_LAST) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, first-error capture and the registered error strobe
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_warm_cnt      <= 4'd0;
            r_idx           <= '0;
            r_first_err_idx <= c_IDX_NONE;
            r_err_cnt       <= '0;
            r_err_pulse     <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_start_ok) begin
                r_warm_cnt      <= 4'd0;
                r_idx           <= '0;
                r_first_err_idx <= c_IDX_NONE;
                r_err_cnt       <= '0;
            end else begin
                if (r_state == ST_WARM) begin
                    r_warm_cnt <= r_warm_cnt + 4'd1;
                end
                if (r_state == ST_CHECK) begin
                    r_idx <= r_idx + 1'b1;
                    if (w_neq) begin
                        r_err_pulse <= 1'b1;
                        if (r_err_cnt != c_CNT_MAX) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (r_first_err_idx == c_IDX_NONE) begin
                            r_first_err_idx <= r_idx;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BUSY          = (r_state == ST_WARM) || (r_state == ST_CHECK);
    assign DONE          = (r_state == ST_DONE);
    assign PASS          = (r_state == ST_DONE) && (r_err_cnt == '0);
    assign ERR_PULSE     = r_err_pulse;
    assign ERR_CNT       = r_err_cnt;
    assign FIRST_ERR_IDX = r_first_err_idx;

endmodule : xor2_wdff_checker
`default_nettype wire

// File: tb/tb_xor2_wdff_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_xor2_wdff_checker
//  Description : Scoreboard bench for xor2_wdff_checker. A behavioural XOR2
//                cell (with optional fault modes) feeds the checker; the
//                stimulus process predicts error strobes and run results, a
//                monitor process pops and compares them as the DUT reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor2_wdff_checker;
    import xor2_wdff_pkg::*;

    localparam int N   = 64;
    localparam int WU  = 1;
    localparam int CW  = 8;
    localparam int IW  = 16;
    localparam int N1  = 40;
    localparam int CW1 = 4;
    localparam int SAT_EXP  = (N1 > (1 << CW1) - 1) ? (1 << CW1) - 1 : N1;
    localparam int IDX_NONE_INT = (1 << IW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0, start = 1'b0, in_a = 1'b0, in_b = 1'b0;
    logic inject = 1'b0, ignore_ce = 1'b0;
    logic cell_q, ref_q, dut_o, sat_o;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    logic          busy0, done0, pass0, pulse0;
    logic [CW-1:0] cnt0;
    logic [IW-1:0] first0;
    logic           busy1, done1, pass1, pulse1;
    logic [CW1-1:0] cnt1;
    logic [IW-1:0]  first1;

    typedef struct {
        int cnt;
        int first;
        int pass;
        int busy_len;
    } res_t;
    res_t res_q[$];
    int   pulse_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell under check: O <= A ^ B on enabled edges; optionally ignores CE.
    always @(posedge clk or posedge rst)
        if (rst) cell_q <= 1'b0;
        else if (ce || ignore_ce) cell_q <= in_a ^ in_b;

    // Bench's own notion of the correct cell output.
    always @(posedge clk or posedge rst)
        if (rst) ref_q <= 1'b0;
        else if (ce) ref_q <= in_a ^ in_b;

    assign dut_o = cell_q ^ inject;
    assign sat_o = ~ref_q;

    xor2_wdff_checker #(.NUM_CHECKS(N), .WARMUP(WU), .CNT_W(CW), .IDX_W(IW)) dut (
        .CLK(clk), .RESET(rst), .CE(ce), .START(start), .IN_A(in_a), .IN_B(in_b),
        .DUT_O(dut_o), .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_PULSE(pulse0),
        .ERR_CNT(cnt0), .FIRST_ERR_IDX(first0)
    );

    xor2_wdff_checker #(.NUM_CHECKS(N1), .WARMUP(0), .CNT_W(CW1), .IDX_W(IW)) dut_sat (
        .CLK(clk), .RESET(rst), .CE(ce), .START(start), .IN_A(in_a), .IN_B(in_b),
        .DUT_O(sat_o), .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_PULSE(pulse1),
        .ERR_CNT(cnt1), .FIRST_ERR_IDX(first1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes an error or ends a run.
    initial begin : mon
        int   e;
        res_t r;
        bit   busy_d, done_d, done1_d;
        int   busy_run;
        busy_d = 0; done_d = 0; done1_d = 0; busy_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_d = 0; done_d = 0; done1_d = 0; busy_run = 0;
            end else begin
                if (busy0) busy_run = busy_d ? busy_run + 1 : 1;
                busy_d = busy0;
                if (pulse0) begin
                    if (pulse_q.size() == 0) begin
                        chk("err_pulse_unexpected", longint'(pulse0), 0);
                    end else begin
                        e = pulse_q.pop_front();
                        chk("err_pulse_cycle", cyc, e);
                    end
                end
                if (done0 && !done_d) begin
                    if (res_q.size() == 0) begin
                        chk("done_unexpected", longint'(done0), 0);
                    end else begin
                        r = res_q.pop_front();
                        chk("err_cnt", longint'(cnt0), r.cnt);
                        chk("first_err_idx", longint'(first0), r.first);
                        chk("pass", longint'(pass0), r.pass);
                        chk("busy_len", busy_run, r.busy_len);
                    end
                end
                done_d = done0;
                if (done1 && !done1_d) begin
                    chk("sat_err_cnt", longint'(cnt1), SAT_EXP);
                    chk("sat_first_err_idx", longint'(first1), 0);
                    chk("sat_pass", longint'(pass1), 0);
                end
                done1_d = done1;
            end
        end
    end

    // mode 0: CE=1, random operands. mode 1: CE 4 on / 4 off, IN_A=1 and
    // IN_B toggled only at the start of a CE=0 phase.
    task automatic drive(input int mode, input int s);
        if (mode == 0) begin
            ce   = 1'b1;
            in_a = 1'($urandom_range(0, 1));
            in_b = 1'($urandom_range(0, 1));
        end else begin
            ce   = ((s / 4) % 2) == 0;
            in_a = 1'b1;
            if (s % 8 == 4) in_b = ~in_b;
        end
    endtask

    task automatic do_run(input int mode, input int fa, input int fb,
                          input bit mid_start, input int rst_at, input bit chk_restart);
        int   nerr  = 0;
        int   first = -1;
        int   s     = 0;
        res_t r;
        if (mode == 1) in_b = 1'b0;
        start = 1'b1;
        drive(mode, s); s++;
        @(posedge clk); #1;
        start = 1'b0;
        if (chk_restart) begin
            chk("restart_done_low", longint'(done0), 0);
            chk("restart_busy", longint'(busy0), 1);
            chk("restart_cnt_clr", longint'(cnt0), 0);
            chk("restart_first_clr", longint'(first0), IDX_NONE_INT);
        end
        repeat (WU) begin
            drive(mode, s); s++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) begin
            drive(mode, s); s++;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", longint'(busy0), 0);
                chk("rst_done", longint'(done0), 0);
                chk("rst_pass", longint'(pass0), 0);
                chk("rst_pulse", longint'(pulse0), 0);
                chk("rst_cnt", longint'(cnt0), 0);
                chk("rst_first", longint'(first0), IDX_NONE_INT);
                chk("rst_sat_busy", longint'(busy1), 0);
                @(posedge clk); #1;
                rst = 1'b0;
                pulse_q.delete();
                ce = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            inject = (k == fa) || (k == fb);
            if (mid_start && k == 10) start = 1'b1;
            if ((cell_q ^ inject) != ref_q) begin
                if (first < 0) first = k;
                nerr++;
                pulse_q.push_back(cyc + 1);
            end
            @(posedge clk); #1;
            start  = 1'b0;
            inject = 1'b0;
        end
        r.cnt      = (nerr > (1 << CW) - 1) ? (1 << CW) - 1 : nerr;
        r.first    = (first < 0) ? IDX_NONE_INT : first;
        r.pass     = (nerr == 0) ? 1 : 0;
        r.busy_len = WU + N;
        res_q.push_back(r);
        ignore_ce = 1'b0;
        ce        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("result_consumed", res_q.size(), 0);
        chk("pulses_consumed", pulse_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_done", longint'(done0), 0);
        chk("reset_pass", longint'(pass0), 0);
        chk("reset_pulse", longint'(pulse0), 0);
        chk("reset_cnt", longint'(cnt0), 0);
        chk("reset_first", longint'(first0), IDX_NONE_INT);
        rst = 1'b0;
        ce  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        // Clean golden loop.
        do_run(0, -1, -1, 1'b0, -1, 1'b0);
        // Faults injected at check indices 5 and 9.
        do_run(0, 5, 9, 1'b0, -1, 1'b0);
        // Restart from DONE, with an ignored START in mid-run.
        do_run(0, -1, -1, 1'b1, -1, 1'b1);
        // CE hold behaviour: clean cell, then a cell that ignores CE.
        do_run(1, -1, -1, 1'b0, -1, 1'b0);
        ignore_ce = 1'b1;
        do_run(1, -1, -1, 1'b0, -1, 1'b0);
        // Reset at check index 20, then a full clean run.
        do_run(0, -1, -1, 1'b0, 20, 1'b0);
        do_run(0, -1, -1, 1'b0, -1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_xor2_wdff_checker
`default_nettype wire
